// File: rtl/color_fsm_driver.sv
// Command driver for the Color FSM: walks it to a requested state one hop at a time
// and checks every hop against the FSM's colour output.
module color_fsm_driver #(
  parameter int CHECK_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_target,
  output logic [1:0] cmd_out,
  input  logic [1:0] color_in,
  input  logic       sync,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] cur_state
);
  localparam int CW = (CHECK_DELAY < 2) ? 1 : $clog2(CHECK_DELAY + 1);
  localparam logic [1:0] BLUE    = 2'd0;
  localparam logic [1:0] RED     = 2'd1;
  localparam logic [1:0] ILLEGAL = 2'd3;
  localparam logic [1:0] NOP     = 2'h3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

  state_t          state;
  logic [1:0]      target;
  logic [CW-1:0]   cnt;

  // Every route between Blue and HSV_idle passes through Red
  function automatic logic [1:0] hop_cmd(input logic [1:0] s, input logic [1:0] t);
    case (s)
      BLUE:    hop_cmd = 2'd1;
      RED:     hop_cmd = (t == BLUE) ? 2'd1 : 2'd2;
      default: hop_cmd = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] hop_dst(input logic [1:0] s, input logic [1:0] t);
    hop_dst = (s == RED) ? t : RED;
  endfunction

  // Red and HSV_idle share a code, so the shadow state stays authoritative
  function automatic logic [1:0] color_code(input logic [1:0] s);
    color_code = (s == BLUE) ? 2'h1 : 2'h2;
  endfunction

  assign req_ready = (state == IDLE) && !sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      target    <= RED;
      cnt       <= '0;
      cmd_out   <= NOP;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cur_state <= RED;
    end else begin
      done    <= 1'b0;
      cmd_out <= NOP;
      if (sync) begin
        state     <= IDLE;
        cur_state <= RED;
        err       <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (req_valid) begin
            target <= req_target;
            if (req_target == ILLEGAL) begin
              state <= ERR;
              err   <= 1'b1;
            end else if (req_target == cur_state) begin
              done <= 1'b1;
            end else begin
              state     <= ISSUE;
              busy      <= 1'b1;
              cmd_out   <= hop_cmd(cur_state, req_target);
              cur_state <= hop_dst(cur_state, req_target);
            end
          end
          ISSUE: begin
            state <= WAIT;
            cnt   <= CW'(CHECK_DELAY);
          end
          WAIT: if (cnt == CW'(1)) begin
            if (color_in != color_code(cur_state)) begin
              state <= ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else if (cur_state == target) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              cmd_out   <= hop_cmd(cur_state, target);
              cur_state <= hop_dst(cur_state, target);
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
          ERR: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_color_fsm_driver.sv
// Bench for color_fsm_driver: CHECK_DELAY=1 and 3 side by side, each with a Color FSM
// environment, checked every cycle against a route/schedule model.
module tb_color_fsm_driver;
  localparam logic [1:0] BLUE = 2'd0, RED = 2'd1, HSV = 2'd2, NOP = 2'h3;

  logic       clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, sync = 1'b0, stuck = 1'b0;
  logic [1:0] req_target = 2'd0;
  logic       ready_w[2], busy_w[2], done_w[2], err_w[2];
  logic [1:0] cmd_w[2], cur_w[2], color_w[2];
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  color_fsm_driver #(.CHECK_DELAY(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_w[0]),
    .req_target(req_target), .cmd_out(cmd_w[0]), .color_in(color_w[0]), .sync(sync),
    .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .cur_state(cur_w[0]));

  color_fsm_driver #(.CHECK_DELAY(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_w[1]),
    .req_target(req_target), .cmd_out(cmd_w[1]), .color_in(color_w[1]), .sync(sync),
    .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .cur_state(cur_w[1]));

  function automatic int dly(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] code(input logic [1:0] s);
    return (s == BLUE) ? 2'h1 : 2'h2;
  endfunction

  // Color FSM environment; the D=3 path gets two extra register stages on its output
  function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic [1:0] c);
    if (c == 2'd1 && s == BLUE) return RED;
    if (c == 2'd1 && s == RED)  return BLUE;
    if (c == 2'd2 && s == RED)  return HSV;
    if (c == 2'd0 && s == HSV)  return RED;
    return s;
  endfunction

  logic [1:0] fsm[2];
  logic [1:0] cpipe[2][2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fsm[i] <= RED; cpipe[i][0] <= 2'h2; cpipe[i][1] <= 2'h2;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        fsm[i]      <= sync ? RED : fsm_next(fsm[i], cmd_w[i]);
        cpipe[i][0] <= code(fsm[i]);
        cpipe[i][1] <= cpipe[i][0];
      end
    end
  end
  assign color_w[0] = stuck ? 2'h2 : code(fsm[0]);
  assign color_w[1] = stuck ? 2'h2 : cpipe[1][1];

  // Model: a request becomes a route (list of hops) and a timeline relative to accept
  bit         m_act[2], m_err[2];
  logic [1:0] m_sh[2], m_tgt[2];
  int         m_r[2], m_nh[2], m_fail[2];
  logic [1:0] m_cmd[2][2], m_dst[2][2];
  logic [1:0] e_cmd[2], e_cur[2];
  logic       e_busy[2], e_done[2];

  task automatic plan_route(input int i, input logic [1:0] s, input logic [1:0] t);
    if (s == t) m_nh[i] = 0;
    else if (s == RED) begin
      m_nh[i] = 1; m_cmd[i][0] = (t == BLUE) ? 2'd1 : 2'd2; m_dst[i][0] = t;
    end else if (t == RED) begin
      m_nh[i] = 1; m_cmd[i][0] = (s == BLUE) ? 2'd1 : 2'd0; m_dst[i][0] = RED;
    end else begin
      m_nh[i] = 2;
      m_cmd[i][0] = (s == BLUE) ? 2'd1 : 2'd0; m_dst[i][0] = RED;
      m_cmd[i][1] = (t == BLUE) ? 2'd1 : 2'd2; m_dst[i][1] = t;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_err[i] = 0; m_sh[i] = RED;
      e_cmd[i] = NOP; e_busy[i] = 0; e_done[i] = 0; e_cur[i] = RED;
    end
  endtask

  task automatic model_step();
    int d, last;
    if (!rst_n) begin model_reset(); return; end
    for (int i = 0; i < 2; i++) begin
      d = dly(i);
      if (sync) begin
        m_act[i] = 0; m_err[i] = 0; m_sh[i] = RED;
      end else if (!m_act[i] && !m_err[i] && req_valid) begin
        m_tgt[i] = req_target;
        if (req_target == 2'd3) m_err[i] = 1;
        else begin
          m_act[i] = 1; m_r[i] = 0; m_fail[i] = -1;
          plan_route(i, m_sh[i], req_target);
          for (int k = 0; k < m_nh[i]; k++)
            if (stuck && m_fail[i] < 0 && code(m_dst[i][k]) != 2'h2) m_fail[i] = k;
        end
      end
      e_cmd[i] = NOP; e_busy[i] = 0; e_done[i] = 0;
      if (m_act[i]) begin
        m_r[i]++;
        last = (m_fail[i] >= 0) ? m_fail[i] : m_nh[i] - 1;
        for (int k = 0; k <= last; k++) begin
          if (m_r[i] >= 1 + k * (d + 1)) e_cur[i] = m_dst[i][k];
          if (m_r[i] == 1 + k * (d + 1)) e_cmd[i] = m_cmd[i][k];
        end
        if (m_r[i] < (last + 1) * (d + 1) + 1) e_busy[i] = 1;
        else begin
          m_act[i] = 0;
          if (m_fail[i] >= 0) begin m_err[i] = 1; m_sh[i] = m_dst[i][m_fail[i]]; end
          else begin e_done[i] = 1; m_sh[i] = m_tgt[i]; end
        end
      end
      if (!m_act[i]) e_cur[i] = m_sh[i];
    end
  endtask

  task automatic chk2(input int i, input string nm, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s D=%0d got=%0d expected=%0d at %0t", nm, dly(i), got, exp, $time);
    end
  endtask

  task automatic chk1(input int i, input string nm, input logic got, input logic exp);
    chk2(i, nm, {1'b0, got}, {1'b0, exp});
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk2(i, "cmd_out", cmd_w[i], e_cmd[i]);
      chk2(i, "cur_state", cur_w[i], e_cur[i]);
      chk1(i, "busy", busy_w[i], e_busy[i]);
      chk1(i, "done", done_w[i], e_done[i]);
      chk1(i, "err", err_w[i], m_err[i]);
      chk1(i, "req_ready", ready_w[i], !m_act[i] && !m_err[i] && !sync);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [1:0] t, input bit s);
    @(posedge clk);
    model_step();
    #1;
    rst_n = r;
    if (!r) model_reset();
    req_valid = v; req_target = t; sync = s;
    @(negedge clk);
    compare();
  endtask

  logic [1:0] rc0[16], ru0[16];
  logic       rd0[16], rd1[16], rb0[16], re0[16], rr0[16];

  task automatic rec(input int n);
    for (int r = 1; r <= n; r++) begin
      cycle(1, 0, 2'd0, 0);
      rc0[r] = cmd_w[0]; ru0[r] = cur_w[0]; rd0[r] = done_w[0]; rd1[r] = done_w[1];
      rb0[r] = busy_w[0]; re0[r] = err_w[0]; rr0[r] = ready_w[0];
    end
  endtask

  task automatic req_rec(input logic [1:0] t, input int n);
    cycle(1, 1, t, 0);
    rec(n);
  endtask

  function automatic logic any1(input logic a[16], input int n);
    logic o = 1'b0;
    for (int r = 1; r <= n; r++) o |= a[r];
    return o;
  endfunction

  task automatic chk_reset_vals();
    for (int i = 0; i < 2; i++) begin
      chk2(i, "rst_cmd", cmd_w[i], NOP);
      chk1(i, "rst_ready", ready_w[i], 1'b1);
      chk1(i, "rst_busy", busy_w[i], 1'b0);
      chk1(i, "rst_done", done_w[i], 1'b0);
      chk1(i, "rst_err", err_w[i], 1'b0);
      chk2(i, "rst_cur", cur_w[i], RED);
    end
  endtask

  initial begin
    bit r, s, v;
    logic [1:0] t;
    model_reset();
    repeat (3) cycle(0, 0, 2'd0, 0);
    chk_reset_vals();
    cycle(1, 0, 2'd0, 0);
    chk_reset_vals();

    // Red -> Blue: one hop
    req_rec(BLUE, 6);
    chk2(0, "h1_cmd_a1", rc0[1], 2'd1);
    chk2(0, "h1_cmd_a2", rc0[2], NOP);
    chk1(0, "h1_done_a2", rd0[2], 1'b0);
    chk1(0, "h1_done_a3", rd0[3], 1'b1);
    chk2(0, "h1_cur_a3", ru0[3], BLUE);
    chk1(1, "h1_done_a4", rd1[4], 1'b0);
    chk1(1, "h1_done_a5", rd1[5], 1'b1);

    // Blue -> HSV_idle: two hops through Red
    req_rec(HSV, 10);
    chk2(0, "h2_cmd_a1", rc0[1], 2'd1);
    chk2(0, "h2_cmd_a2", rc0[2], NOP);
    chk2(0, "h2_cmd_a3", rc0[3], 2'd2);
    chk2(0, "h2_cmd_a4", rc0[4], NOP);
    chk1(0, "h2_done_a5", rd0[5], 1'b1);
    chk2(0, "h2_cur_a5", ru0[5], HSV);
    chk1(1, "h2_done_a9", rd1[9], 1'b1);

    // HSV_idle -> Red, then a zero-hop request
    req_rec(RED, 6);
    chk2(0, "hr_cmd_a1", rc0[1], 2'd0);
    req_rec(RED, 3);
    chk1(0, "z_done_a1", rd0[1], 1'b1);
    chk2(0, "z_cmd_a1", rc0[1], NOP);
    chk1(0, "z_busy_any", any1(rb0, 3), 1'b0);

    // Illegal target, cleared by sync
    req_rec(2'd3, 1);
    chk1(0, "ill_err_a1", re0[1], 1'b1);
    chk1(0, "ill_ready_a1", rr0[1], 1'b0);
    cycle(1, 0, 2'd0, 1);
    cycle(1, 0, 2'd0, 0);
    chk1(0, "sync_err", err_w[0], 1'b0);
    chk2(0, "sync_cur", cur_w[0], RED);
    chk1(0, "sync_ready", ready_w[0], 1'b1);

    // Colour stuck at 2'h2: the hop to Blue must fail its check
    stuck = 1'b1;
    req_rec(BLUE, 5);
    chk1(0, "stk_err_a2", re0[2], 1'b0);
    chk1(0, "stk_err_a3", re0[3], 1'b1);
    chk1(0, "stk_done_any", any1(rd0, 5), 1'b0);
    cycle(1, 0, 2'd0, 1);
    stuck = 1'b0;
    cycle(1, 0, 2'd0, 0);

    // Reset during WAIT of a two-hop request
    req_rec(BLUE, 6);
    cycle(1, 1, HSV, 0);
    cycle(1, 0, 2'd0, 0);
    cycle(0, 0, 2'd0, 0);
    chk_reset_vals();
    rec(6);
    chk1(0, "rst_done_any", any1(rd0, 6), 1'b0);
    chk2(0, "rst_cur_after", ru0[6], RED);

    // sync during ISSUE drops the request; the next one starts from Red
    cycle(1, 1, BLUE, 0);
    cycle(1, 0, 2'd0, 1);
    chk2(0, "si_cmd", cmd_w[0], 2'd1);
    chk1(0, "si_busy", busy_w[0], 1'b1);
    rec(4);
    chk1(0, "si_done_any", any1(rd0, 4), 1'b0);
    chk1(1, "si_done_any", any1(rd1, 4), 1'b0);
    chk2(0, "si_cur", ru0[4], RED);
    req_rec(HSV, 6);
    chk2(0, "si_next_cmd", rc0[1], 2'd2);
    chk2(0, "si_next_cur", ru0[1], HSV);
    chk1(0, "si_next_done", rd0[3], 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(599) != 0);
      s = r && ($urandom_range(99) < ((m_err[0] || m_err[1]) ? 30 : 2));
      v = 1'($urandom_range(1));
      t = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
      if (!m_act[0] && !m_act[1] && !m_err[0] && !m_err[1] && $urandom_range(29) == 0)
        stuck = !stuck;
      cycle(r, v, t, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
